// File: rtl/spi_mode_pkg.sv
// SPI mode encoding and clock polarity/phase helpers shared by SPI blocks.
package spi_mode_pkg;

  typedef enum logic [1:0] {
    SMODE0 = 2'd0,
    SMODE1 = 2'd1,
    SMODE2 = 2'd2,
    SMODE3 = 2'd3
  } spi_mode_e;

  localparam int SPI_FRAME_BITS = 8;

  function automatic logic spi_cpol(spi_mode_e m);
    return (m == SMODE2) || (m == SMODE3);
  endfunction

  function automatic logic spi_cpha(spi_mode_e m);
    return (m == SMODE1) || (m == SMODE3);
  endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period timer: counts CLK_DIV enabled cycles, pulses tick on the last one.
module spi_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, all four modes; registered SCLK/SS/MOSI.
// IDLE: ready, SS high | SETUP: SS low, first bit | XFER: 16 SCLK edges | HOLD: SCLK at idle | DONE: pulse done
module spi_master
  import spi_mode_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  spi_mode_e                 mode,
  input  logic                      start,
  input  logic [SPI_FRAME_BITS-1:0] tx_data,
  output logic                      ready,
  output logic                      done,
  output logic [SPI_FRAME_BITS-1:0] rx_data,
  output logic                      SCLK,
  output logic                      SS,
  output logic                      MOSI,
  input  logic                      MISO
);

  localparam logic [4:0] EDGE_LAST = 5'(2 * SPI_FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_e;

  state_e                    state, state_next;
  spi_mode_e                 mode_lat, mode_next;
  logic [SPI_FRAME_BITS-1:0] tx_lat, tx_next;
  logic [SPI_FRAME_BITS-1:0] rx_shift, rx_shift_next;
  logic [SPI_FRAME_BITS-1:0] rx_data_next;
  logic [4:0]                edge_cnt, edge_cnt_next;
  logic                      sclk_next, ss_next, mosi_next, done_next;
  logic                      cpol, cpha, tick, tick_en, tick_clear;
  logic [2:0]                bit_idx;

  assign cpol       = spi_cpol(mode_lat);
  assign cpha       = spi_cpha(mode_lat);
  assign tick_en    = (state == SETUP) || (state == XFER) || (state == HOLD);
  assign tick_clear = (state == IDLE) && start;
  assign ready      = (state == IDLE);
  // Bit driven on a drive edge: (edge_cnt+1)/2 bits have already gone out.
  assign bit_idx    = 3'd7 - edge_cnt[3:1] - {2'b00, edge_cnt[0]};

  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (tick_clear),
    .en    (tick_en),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_lat <= SMODE0;
      tx_lat   <= '0;
      rx_shift <= '0;
      edge_cnt <= '0;
      SCLK     <= 1'b0;
      SS       <= 1'b1;
      MOSI     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_next;
      mode_lat <= mode_next;
      tx_lat   <= tx_next;
      rx_shift <= rx_shift_next;
      edge_cnt <= edge_cnt_next;
      SCLK     <= sclk_next;
      SS       <= ss_next;
      MOSI     <= mosi_next;
      done     <= done_next;
      rx_data  <= rx_data_next;
    end
  end

  always_comb begin
    state_next    = state;
    mode_next     = mode_lat;
    tx_next       = tx_lat;
    rx_shift_next = rx_shift;
    edge_cnt_next = edge_cnt;
    sclk_next     = SCLK;
    ss_next       = SS;
    mosi_next     = MOSI;
    done_next     = 1'b0;
    rx_data_next  = rx_data;
    case (state)
      IDLE: begin
        ss_next   = 1'b1;
        sclk_next = spi_cpol(mode);
        if (start) begin
          mode_next     = mode;
          tx_next       = tx_data;
          rx_shift_next = '0;
          edge_cnt_next = '0;
          state_next    = SETUP;
        end
      end
      SETUP: begin
        ss_next = 1'b0;
        if (!cpha) mosi_next = tx_lat[SPI_FRAME_BITS-1];
        if (tick) state_next = XFER;
      end
      XFER: begin
        if (tick) begin
          sclk_next     = ~SCLK;
          edge_cnt_next = edge_cnt + 5'd1;
          // Even edge_cnt is a leading edge; CPHA picks which edge samples.
          if (edge_cnt[0] == cpha) begin
            rx_shift_next = {rx_shift[SPI_FRAME_BITS-2:0], MISO};
          end else if (edge_cnt != EDGE_LAST) begin
            mosi_next = tx_lat[bit_idx];
          end
          if (edge_cnt == EDGE_LAST) state_next = HOLD;
        end
      end
      HOLD: begin
        sclk_next = cpol;
        if (tick) state_next = DONE;
      end
      DONE: begin
        ss_next      = 1'b1;
        done_next    = 1'b1;
        rx_data_next = rx_shift;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and slave-model frames in all modes.
module tb_spi_master;
  import spi_mode_pkg::*;

  localparam int DIV      = 4;
  localparam int DONE_LAT = 18 * DIV + 1;
  localparam int PERIOD   = 18 * DIV + 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  spi_mode_e  mode = SMODE0;
  logic [7:0] tx_data = 8'h00;
  logic       ready, done, SCLK, SS, MOSI, MISO;
  logic [7:0] rx_data;

  logic       loop_en = 1'b1;
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  logic [3:0] s_idx = 4'd8;
  logic       slave_bit;

  int   n_vec = 0, n_err = 0;
  int   edge_n = 0, rise_cnt = 0, fall_cnt = 0, done_cnt = 0, mosi_bad = 0;
  logic sclk_prev = 1'b0, mosi_prev = 1'b0;
  int   acc, r0, f0, d0, m0, t_done1, hi_cnt;

  spi_master #(.CLK_DIV(DIV)) dut (
    .clock   (clock),
    .reset   (reset),
    .mode    (mode),
    .start   (start),
    .tx_data (tx_data),
    .ready   (ready),
    .done    (done),
    .rx_data (rx_data),
    .SCLK    (SCLK),
    .SS      (SS),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_n <= edge_n + 1;

  // Slave: shifts out on falling SCLK, captures on rising SCLK.
  assign slave_bit = (s_idx < 4'd8) ? slave_tx[s_idx[2:0]] : 1'b0;
  assign MISO      = loop_en ? MOSI : slave_bit;

  always @(negedge SCLK or posedge SS) begin
    if (SS) s_idx <= 4'd8;
    else    s_idx <= s_idx - 4'd1;
  end

  always @(posedge SCLK) if (!SS) slave_rx <= {slave_rx[6:0], MOSI};

  always @(negedge clock) begin
    if (!SS && SCLK && !sclk_prev) begin
      rise_cnt++;
      if (MOSI !== mosi_prev) mosi_bad++;
    end
    if (!SS && !SCLK && sclk_prev) fall_cnt++;
    if (done === 1'b1) done_cnt++;
    sclk_prev = SCLK;
    mosi_prev = MOSI;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input spi_mode_e m, input logic [7:0] d);
    @(negedge clock);
    mode    = m;
    tx_data = d;
    start   = 1'b1;
    r0 = rise_cnt; f0 = fall_cnt; d0 = done_cnt; m0 = mosi_bad;
    @(negedge clock);
    acc   = edge_n;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max_cyc) begin
      @(negedge clock);
      k++;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_loop(input string tag, input spi_mode_e m, input logic [7:0] d,
                          input logic idle);
    loop_en = 1'b1;
    @(negedge clock);
    mode = m;
    repeat (2) @(negedge clock);
    check({tag, "_sclk_pre"}, 32'(SCLK), 32'(idle));
    start_frame(m, d);
    wait_done(200);
    check({tag, "_done_lat"}, edge_n - acc, DONE_LAT);
    check({tag, "_rx"}, 32'(rx_data), 32'(d));
    @(negedge clock);
    check({tag, "_sclk_post"}, 32'(SCLK), 32'(idle));
  endtask

  initial begin
    #12;
    check("rst_ss", 32'(SS), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx_data), 32'h00);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // SMODE0 loopback
    loop_en = 1'b1;
    start_frame(SMODE0, 8'hA5);
    wait_done(200);
    check("m0_done_lat", edge_n - acc, DONE_LAT);
    check("m0_rx", 32'(rx_data), 32'hA5);
    check("m0_rise", rise_cnt - r0, 32'd8);
    check("m0_fall", fall_cnt - f0, 32'd8);
    check("m0_mosi_stable", mosi_bad - m0, 32'd0);
    check("m0_ss_high", 32'(SS), 32'd1);
    @(negedge clock);
    check("m0_sclk_idle", 32'(SCLK), 32'd0);
    check("m0_ready", 32'(ready), 32'd1);

    // SMODE3 against the slave model
    loop_en  = 1'b0;
    slave_tx = 8'h3C;
    mode     = SMODE3;
    repeat (2) @(negedge clock);
    check("m3_sclk_pre", 32'(SCLK), 32'd1);
    start_frame(SMODE3, 8'hC3);
    wait_done(200);
    check("m3_rx", 32'(rx_data), 32'h3C);
    check("m3_slave_rx", 32'(slave_rx), 32'hC3);
    check("m3_rise", rise_cnt - r0, 32'd8);
    @(negedge clock);
    check("m3_sclk_post", 32'(SCLK), 32'd1);

    run_loop("m1", SMODE1, 8'h81, 1'b0);
    run_loop("m2", SMODE2, 8'h81, 1'b1);

    // start mid-frame is ignored
    run_loop("m0b", SMODE0, 8'h5A, 1'b0);
    start_frame(SMODE0, 8'h5A);
    repeat (19) @(negedge clock);
    start   = 1'b1;
    tx_data = 8'hFF;
    @(negedge clock);
    start   = 1'b0;
    tx_data = 8'h00;
    wait_done(200);
    check("ign_rx", 32'(rx_data), 32'h5A);
    repeat (10) @(negedge clock);
    check("ign_done_cnt", done_cnt - d0, 32'd1);
    check("ign_idle", 32'(ready), 32'd1);

    // reset mid-frame
    start_frame(SMODE0, 8'h96);
    repeat (30) @(negedge clock);
    d0    = done_cnt;
    reset = 1'b1;
    #1;
    check("mid_rst_ss", 32'(SS), 32'd1);
    check("mid_rst_sclk", 32'(SCLK), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_rx", 32'(rx_data), 32'h00);
    check("mid_rst_mosi", 32'(MOSI), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (80) @(negedge clock);
    check("mid_rst_no_done", done_cnt - d0, 32'd0);
    start_frame(SMODE0, 8'h3E);
    wait_done(200);
    check("post_rst_rx", 32'(rx_data), 32'h3E);
    check("post_rst_lat", edge_n - acc, DONE_LAT);

    // back-to-back with start held high
    @(negedge clock);
    mode    = SMODE0;
    tx_data = 8'h55;
    start   = 1'b1;
    wait_done(200);
    t_done1 = edge_n;
    check("b2b_rx1", 32'(rx_data), 32'h55);
    hi_cnt = 0;
    while (SS === 1'b1 && hi_cnt < 10) begin
      hi_cnt++;
      @(negedge clock);
    end
    check("b2b_ss_gap", hi_cnt, 32'd2);
    wait_done(200);
    start = 1'b0;
    check("b2b_period", edge_n - t_done1, PERIOD);
    check("b2b_rx2", 32'(rx_data), 32'h55);
    repeat (5) @(negedge clock);
    check("b2b_idle_ss", 32'(SS), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
